// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial signed subtractor: FSM state encoding
// and the counter-width helper.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that indexes n chunks; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational Chunk-bit adder slice. The top shares one instance across
// all cycles of an operation, feeding it one chunk per cycle.
module sub_chunk #(
    parameter int Chunk = 8
) (
    input  logic [Chunk-1:0] x,
    input  logic [Chunk-1:0] y,
    input  logic             cin,
    output logic [Chunk-1:0] s,
    output logic             cout
);

    // Chunk+1 bit sum; the chunks are unsigned so no sign extension is needed.
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{Chunk{1'b0}}, cin};

endmodule

// File: rtl/sub_serial_signed.sv
// Multi-cycle signed subtractor: diff = a - b, computed as a + ~b + 1 one
// chunk per cycle from LSB to MSB, behind a valid/ready handshake. Reports
// two's-complement overflow and unsigned borrow alongside the result.
module sub_serial_signed
    import sub_serial_pkg::*;
#(
    parameter int Bits  = 64,
    parameter int Chunk = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Bits-1:0] a,
    input  logic [Bits-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Bits-1:0] diff,
    output logic            overflow,
    output logic            borrow
);

    localparam int            N       = Bits / Chunk;
    localparam int            CW      = cnt_width(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            bsign_q;
    logic [Bits-1:0] opa_q, opb_q, diff_q;
    logic            overflow_q, borrow_q;

    logic             accept;
    logic             last;
    int               base;
    logic [Chunk-1:0] x, y, s;
    logic             cout;

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (cnt_q == LastCnt);
    assign base   = int'(cnt_q) * Chunk;
    assign x      = opa_q[base +: Chunk];
    assign y      = opb_q[base +: Chunk];

    sub_chunk #(.Chunk(Chunk)) u_chunk (
        .x    (x),
        .y    (y),
        .cin  (carry_q),
        .s    (s),
        .cout (cout)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on the last
    // chunk, DONE -> IDLE when the consumer takes the result.
    // NOTE: state_d is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand capture, chunk-serial accumulation and flag registration.
    // The flags are written on the edge that enters DONE and then hold
    // until the next accept's operation completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            bsign_q    <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            diff_q     <= '0;
            overflow_q <= 1'b0;
            borrow_q   <= 1'b0;
        end else if (accept) begin
            opa_q   <= a;
            opb_q   <= ~b;
            bsign_q <= b[Bits-1];
            carry_q <= 1'b1;
            cnt_q   <= '0;
            diff_q  <= '0;
        end else if (state_q == RUN) begin
            diff_q[base +: Chunk] <= s;
            carry_q               <= cout;
            cnt_q                 <= cnt_q + 1'b1;
            if (last) begin
                borrow_q   <= ~cout;
                overflow_q <= (opa_q[Bits-1] != bsign_q) && (s[Chunk-1] != opa_q[Bits-1]);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign overflow  = overflow_q;
    assign borrow    = borrow_q;

endmodule
